// File: rtl/rv_pipe_pkg.sv
// Shared IF/ID pipeline types: datapath width, the canonical NOP, the fetch packet
// and the skid-buffer occupancy states.
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/if_id_buffer_sat_counter.sv
// Saturating event counter used for IF/ID performance statistics; only compiled when
// IF_ID_PERF_EN is defined, since nothing else instantiates it.
`ifdef IF_ID_PERF_EN
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/if_id_buffer.sv
// IF/ID boundary: two-entry skid buffer (MAIN drives ID, SKID absorbs one overflow packet)
// with registered if_ready and synchronous flush. Define IF_ID_PERF_EN for stall/flush counters.
module if_id_buffer
    import rv_pipe_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [XLEN-1:0] if_inst,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst,
`ifdef IF_ID_PERF_EN
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
`endif
    output buf_state_t      dbg_state
);

    // Handshake: a packet moves on a side only in a cycle where both valid and ready are
    // high at the rising edge; valid never waits on ready, and if_ready is a flop output
    // so no combinational path exists from id_ready back to the IF stage.

    buf_state_t state, state_next;
    fetch_pkt_t main_pkt, skid_pkt, in_pkt;
    logic       if_ready_q;
    logic       accept, deliver;
    logic       load_main_in, load_main_skid, load_skid;

    assign in_pkt  = '{pc: if_pc, pc4: if_pc4, inst: if_inst};
    assign accept  = if_valid && if_ready_q;
    assign deliver = id_valid && id_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            if_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            if_ready_q <= (state_next != FULL);
        end
    end

    // Flush wins over everything and suppresses loads so a dropped packet never reaches id_*.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (deliver) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        id_valid  = (state != EMPTY);
        if_ready  = if_ready_q;
        id_pc     = main_pkt.pc;
        id_pc4    = main_pkt.pc4;
        id_inst   = id_valid ? main_pkt.inst : NOP_INST;
        dbg_state = state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_pkt <= '{pc: '0, pc4: '0, inst: NOP_INST};
            skid_pkt <= '0;
        end else begin
            if (load_main_in) begin
                main_pkt <= in_pkt;
            end else if (load_main_skid) begin
                main_pkt <= skid_pkt;
            end
            if (load_skid) begin
                skid_pkt <= in_pkt;
            end
        end
    end

`ifdef IF_ID_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = if_valid && !if_ready_q;
    assign flush_inc = flush && (id_valid || accept);

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule
